dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Load/store sequencer between the pipeline MEM stage and the word-only data memory (word-addressed, combinational read, write on posedge when ctrl_w).
- Converts lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses.
- Sub-word stores are done as read-modify-write.
- Alignment and range faults are reported without touching memory.

Parameters:
MEM_BYTES, 1024, data memory size in bytes; byte address >= MEM_BYTES is a range fault

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=illegal (fault)
req_signed  input  1  loads: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores/faults)
resp_err  output  1  fault flag, valid with resp_valid
mem_addr  output  32  word address to memory ({req_addr[31:2],2'b00})
mem_ctrl_r  output  1  memory read enable
mem_ctrl_w  output  1  memory write enable
mem_wdata  output  32  memory write word
mem_rdata  input  32  memory read word (combinational from mem_addr/ctrl_r)

Behaviour:
- Reset: state=IDLE; latched addr/size/signed/wdata/old-word = 0; resp_valid=0; resp_rdata=0; resp_err=0; mem_ctrl_r=0; mem_ctrl_w=0; mem_addr=0; mem_wdata=0.
- Reset dominates everything. mem_ctrl_w is forced 0 in any cycle with rst=1, so reset during WR produces no write.
- States: IDLE, RD, WR, RESP.
- Byte lanes are little-endian:
  - Byte k (addr[1:0]=k) is bits [8k+7:8k].
  - Half at addr[1] is bits [16*addr[1]+15 : 16*addr[1]].
- IDLE: req_ready=1. On req_valid, latch all request fields and check for a fault.
  - Fault conditions: half with addr[0]=1; word with addr[1:0]!=0; size=11; addr >= MEM_BYTES.
  - Fault -> RESP with err=1, no mem_ctrl_r/mem_ctrl_w ever asserted.
  - Load -> RD. Sub-word store -> RD. Word store -> WR.
- RD (1 cycle):
  - Drive mem_ctrl_r=1 and mem_addr. Capture mem_rdata at the clock edge.
  - Load: select the lane, extend per req_signed into resp_rdata register, -> RESP.
  - Sub-word store: capture old word, -> WR.
- WR (1 cycle):
  - Drive mem_ctrl_w=1, mem_addr, and mem_wdata.
  - Word store: mem_wdata = req_wdata.
  - Sub-word store: old word with the target lane(s) replaced by req_wdata[7:0] or [15:0]; other bytes unchanged.
  - Next state RESP.
- RESP (1 cycle): resp_valid=1, resp_err per fault, resp_rdata valid (0 for stores/faults), then IDLE.
- No response backpressure; resp_valid is a single-cycle pulse.
- Latency, counted from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - fault: 1 cycle
- Next accept is possible the cycle after RESP.
- mem_ctrl_r and mem_ctrl_w are never high together. Both are 0 in IDLE and RESP.
- mem_wdata is 0 outside WR.
- req_valid outside IDLE is ignored, since req_ready=0 there. Requester must hold the request until it sees ready.
- Back-to-back request in the cycle after RESP is accepted normally.

Test Plan:
1. Preload mem[1]=0x8899AABB; lb addr 0x5, signed -> resp_rdata=0xFFFFFFAA, err=0, exactly 2 cycles after accept; lbu addr 0x7 -> 0x00000088.
2. mem[2]=0x11223344; sh addr 0xA, wdata 0x0000BEEF -> RD then WR cycle with mem_wdata=0xBEEF3344, mem_addr=0x8; later lw 0x8 -> 0xBEEF3344.
3. sw addr 0x10 data 0xDEADBEEF -> single mem_ctrl_w cycle, no mem_ctrl_r cycle, resp_valid 2 cycles after accept; lhu 0x12 -> 0x0000DEAD; lh 0x12 signed -> 0xFFFFDEAD.
4. Faults: lw 0x6, sh 0x3, size=11, sw 0x400 (MEM_BYTES=1024) -> each gives resp_valid with err=1 one cycle after accept, mem_ctrl_r=mem_ctrl_w=0 throughout, memory unchanged.
5. Assert rst in the WR cycle of sb 0x0 -> no write occurs (mem[0] unchanged), no resp_valid, all outputs 0 next cycle, req_ready=1.
6. Hold req_valid high continuously with alternating lw/sb -> one accept per transaction, req_ready low in RD/WR/RESP, ignored requests cause no memory activity.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
//   Load/store sequencer between the MEM stage and a word-only data memory.
//   Byte/half/word loads and stores are turned into word accesses. Sub-word
//   stores are done as read-modify-write. Misaligned, illegal-size and
//   out-of-range requests return err=1 without any memory activity.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : request handshake (valid/ready), we, size, signed,
//                     byte address, right-justified store data
//   resp_*          : single-cycle completion pulse with load data and error
//   mem_*           : word address, read/write strobes, write word, and the
//                     combinational read word returned by the memory
module dm_access_ctrl #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_ctrl_r,
  output logic        mem_ctrl_w,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LP_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;

  // Request fields captured at accept. Only the lane offset of the address
  // is kept; the word address already lives in r_mem_addr.
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem_addr;
  logic        r_mem_ctrl_r;
  logic        r_mem_ctrl_w;
  logic [31:0] r_mem_wdata;

  logic        w_fault;
  logic [31:0] w_word_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_merge;

  assign w_word_addr = {req_addr[31:2], 2'b00};

  // Fault check on the live request (only acted on in IDLE).
  always_comb begin
    w_fault = 1'b0;
    case (req_size)
      2'b01:   w_fault = req_addr[0];
      2'b10:   w_fault = |req_addr[1:0];
      2'b11:   w_fault = 1'b1;
      default: w_fault = 1'b0;
    endcase
    if (req_addr >= LP_LIMIT) begin
      w_fault = 1'b1;
    end
  end

  // Load lane select and extension from the word read in RD.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Sub-word store merge: replicate the store data across the word so every
  // lane already holds the right bits, then pick per byte between the new
  // data and the old word read in RD.
  always_comb begin
    if (r_size == 2'b00) begin
      w_byte_en   = 4'b0001 << r_lane;
      w_wdata_rep = {4{r_wdata[7:0]}};
    end else begin
      w_byte_en   = r_lane[1] ? 4'b1100 : 4'b0011;
      w_wdata_rep = {2{r_wdata}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merge[8*gi +: 8] = w_byte_en[gi] ? w_wdata_rep[8*gi +: 8]
                                                : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_ctrl_r <= 1'b0;
      r_mem_ctrl_w <= 1'b0;
      r_mem_wdata  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
          r_mem_addr   <= 32'h0;
          r_mem_ctrl_r <= 1'b0;
          r_mem_ctrl_w <= 1'b0;
          r_mem_wdata  <= 32'h0;
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_lane   <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            if (w_fault) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_state      <= RESP;
            end else if (req_we && (req_size == 2'b10)) begin
              // Full-word store needs no old data: write straight away.
              r_mem_addr   <= w_word_addr;
              r_mem_ctrl_w <= 1'b1;
              r_mem_wdata  <= req_wdata;
              r_state      <= WR;
            end else begin
              r_mem_addr   <= w_word_addr;
              r_mem_ctrl_r <= 1'b1;
              r_state      <= RD;
            end
          end
        end
        RD: begin
          r_mem_ctrl_r <= 1'b0;
          if (r_we) begin
            // mem_addr is held for the write of the merged word.
            r_mem_ctrl_w <= 1'b1;
            r_mem_wdata  <= w_merge;
            r_state      <= WR;
          end else begin
            r_mem_addr   <= 32'h0;
            r_resp_rdata <= w_load;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        WR: begin
          r_mem_addr   <= 32'h0;
          r_mem_ctrl_w <= 1'b0;
          r_mem_wdata  <= 32'h0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_ctrl_r = r_mem_ctrl_r;
  // The write strobe is gated by rst so that a reset landing in WR can never
  // commit a half-finished read-modify-write.
  assign mem_ctrl_w = r_mem_ctrl_w & ~rst;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_ctrl_r;
  logic        mem_ctrl_w;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        load_mem = 1'b1;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  dm_access_ctrl #(.MEM_BYTES(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_ctrl_r (mem_ctrl_r),
    .mem_ctrl_w (mem_ctrl_w),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory model: combinational read, write on posedge.
  assign mem_rdata = (mem_ctrl_r && mem_addr < 32'd1024) ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
      mem[0] <= 32'h01020304;
      mem[1] <= 32'h8899AABB;
      mem[2] <= 32'h11223344;
    end else if (mem_ctrl_w) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int rd, input int wr, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
    v.exp_rd = rd; v.exp_wr = wr; v.exp_wd = wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input vec_t v);
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  // One request from accept to response; checks latency, strobe counts,
  // write word/address, response data/error and the one-cycle pulse.
  task automatic run_txn(input vec_t v, input int idx);
    int lat, nrd, nwr, waitc;
    bit got;
    logic [31:0] rd, wd, wa;
    logic er;
    lat = 0; nrd = 0; nwr = 0; waitc = 0; got = 0;
    rd = 32'h0; wd = 32'h0; wa = 32'h0; er = 1'b0;
    @(negedge clk);
    set_req(v);
    req_valid = 1'b1;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk($sformatf("v%0d ready", idx), {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    forever begin
      chk($sformatf("v%0d rw_excl", idx), {31'h0, mem_ctrl_r & mem_ctrl_w}, 32'h0);
      chk($sformatf("v%0d wdata_idle", idx), mem_ctrl_w ? 32'h0 : mem_wdata, 32'h0);
      if (mem_ctrl_r) nrd++;
      if (mem_ctrl_w) begin
        nwr++;
        wd = mem_wdata;
        wa = mem_addr;
      end
      if (resp_valid) begin
        got = 1;
        rd  = resp_rdata;
        er  = resp_err;
      end
      if (got || lat >= 8) break;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d resp_seen", idx), {31'h0, got}, 32'h1);
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
    chk($sformatf("v%0d err", idx), {31'h0, er}, {31'h0, v.exp_err});
    chk($sformatf("v%0d rd_cycles", idx), nrd, v.exp_rd);
    chk($sformatf("v%0d wr_cycles", idx), nwr, v.exp_wr);
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d wr_word", idx), wd, v.exp_wd);
      chk($sformatf("v%0d wr_addr", idx), wa, {v.addr[31:2], 2'b00});
    end
    @(negedge clk);
    chk($sformatf("v%0d pulse_end", idx), {31'h0, resp_valid}, 32'h0);
    chk($sformatf("v%0d ready_back", idx), {31'h0, req_ready}, 32'h1);
    $display("txn v%0d we=%0b size=%0d addr=%h rdata=%h err=%0b lat=%0d", idx, v.we, v.size,
             v.addr, rd, er, lat);
  endtask

  vec_t vt[23];
  vec_t s6[4];

  initial begin
    // loads/stores: we size sgn addr wdata | rdata err lat rd wr wd
    vt[0]  = mk(0, 2'b00, 1, 32'h005, 32'h0,        32'hFFFFFFAA, 0, 2, 1, 0, 32'h0);
    vt[1]  = mk(0, 2'b00, 0, 32'h007, 32'h0,        32'h00000088, 0, 2, 1, 0, 32'h0);
    vt[2]  = mk(1, 2'b01, 0, 32'h00A, 32'h0000BEEF, 32'h0,        0, 3, 1, 1, 32'hBEEF3344);
    vt[3]  = mk(0, 2'b10, 0, 32'h008, 32'h0,        32'hBEEF3344, 0, 2, 1, 0, 32'h0);
    vt[4]  = mk(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 32'hDEADBEEF);
    vt[5]  = mk(0, 2'b01, 0, 32'h012, 32'h0,        32'h0000DEAD, 0, 2, 1, 0, 32'h0);
    vt[6]  = mk(0, 2'b01, 1, 32'h012, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 0, 32'h0);
    vt[7]  = mk(0, 2'b00, 1, 32'h004, 32'h0,        32'hFFFFFFBB, 0, 2, 1, 0, 32'h0);
    vt[8]  = mk(0, 2'b01, 1, 32'h004, 32'h0,        32'hFFFFAABB, 0, 2, 1, 0, 32'h0);
    vt[9]  = mk(0, 2'b01, 0, 32'h006, 32'h0,        32'h00008899, 0, 2, 1, 0, 32'h0);
    vt[10] = mk(1, 2'b00, 0, 32'h011, 32'h123456FF, 32'h0,        0, 3, 1, 1, 32'hDEADFFEF);
    vt[11] = mk(0, 2'b10, 0, 32'h010, 32'h0,        32'hDEADFFEF, 0, 2, 1, 0, 32'h0);
    // faults
    vt[12] = mk(0, 2'b10, 0, 32'h006, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    vt[13] = mk(1, 2'b01, 0, 32'h003, 32'h0000FFFF, 32'h0,        1, 1, 0, 0, 32'h0);
    vt[14] = mk(0, 2'b11, 0, 32'h000, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    vt[15] = mk(1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,        1, 1, 0, 0, 32'h0);
    vt[16] = mk(0, 2'b00, 0, 32'h400, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
    // top-of-memory boundary and post-fault memory contents
    vt[17] = mk(1, 2'b00, 0, 32'h3FF, 32'h0000005A, 32'h0,        0, 3, 1, 1, 32'h5A000000);
    vt[18] = mk(0, 2'b10, 0, 32'h3FC, 32'h0,        32'h5A000000, 0, 2, 1, 0, 32'h0);
    vt[19] = mk(0, 2'b10, 0, 32'h000, 32'h0,        32'h01020304, 0, 2, 1, 0, 32'h0);
    vt[20] = mk(0, 2'b10, 1, 32'h004, 32'h0,        32'h8899AABB, 0, 2, 1, 0, 32'h0);
    vt[21] = mk(1, 2'b01, 0, 32'h004, 32'h00001234, 32'h0,        0, 3, 1, 1, 32'h88991234);
    vt[22] = mk(0, 2'b10, 0, 32'h004, 32'h0,        32'h88991234, 0, 2, 1, 0, 32'h0);

    s6[0] = mk(0, 2'b10, 0, 32'h004, 32'h0,  32'h0, 0, 0, 0, 0, 32'h0);
    s6[1] = mk(1, 2'b00, 0, 32'h008, 32'h77, 32'h0, 0, 0, 0, 0, 32'h0);
    s6[2] = mk(0, 2'b10, 0, 32'h008, 32'h0,  32'h0, 0, 0, 0, 0, 32'h0);
    s6[3] = mk(1, 2'b00, 0, 32'h00C, 32'h11, 32'h0, 0, 0, 0, 0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst mem_ctrl", {30'h0, mem_ctrl_r, mem_ctrl_w}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    load_mem = 1'b0;
    @(negedge clk);
    chk("rst ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 23; i++) run_txn(vt[i], i);

    // Reset during the WR cycle of sb 0x0: no write, no response.
    begin
      @(negedge clk);
      set_req(mk(1, 2'b00, 0, 32'h0, 32'h000000EE, 32'h0, 0, 0, 0, 0, 32'h0));
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstwr rd_cycle", {31'h0, mem_ctrl_r}, 32'h1);
      @(negedge clk);
      chk("rstwr wr_cycle", {31'h0, mem_ctrl_w}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rstwr wr_gated", {31'h0, mem_ctrl_w}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk("rstwr outputs", {28'h0, resp_valid, resp_err, mem_ctrl_r, mem_ctrl_w}, 32'h0);
      chk("rstwr addr_wdata", mem_addr | mem_wdata | resp_rdata, 32'h0);
      chk("rstwr ready", {31'h0, req_ready}, 32'h1);
      chk("rstwr mem0", mem[0], 32'h01020304);
      @(negedge clk);
      chk("rstwr no_resp", {31'h0, resp_valid}, 32'h0);
      $display("txn rst-in-WR sb addr=0 mem0=%h", mem[0]);
    end

    // Request held valid continuously: lw, sb, lw, sb back to back.
    begin
      int acc, nrsp, nrdy, nr, nw, cyc, last_rsp;
      bit pend;
      logic [31:0] rsp_d [4];
      acc = 0; nrsp = 0; nrdy = 0; nr = 0; nw = 0; cyc = 0; last_rsp = -1;
      for (int k = 0; k < 4; k++) rsp_d[k] = 32'hFFFF_FFFF;
      @(negedge clk);
      set_req(s6[0]);
      req_valid = 1'b1;
      while (cyc < 40 && nrsp < 4) begin
        if (req_ready) nrdy++;
        if (mem_ctrl_r) nr++;
        if (mem_ctrl_w) nw++;
        if (resp_valid) begin
          rsp_d[nrsp] = resp_rdata;
          nrsp++;
          last_rsp = cyc;
        end
        pend = req_valid && req_ready;
        @(negedge clk);
        if (pend) begin
          acc++;
          if (acc < 4) set_req(s6[acc]);
          else req_valid = 1'b0;
        end
        cyc++;
      end
      req_valid = 1'b0;
      chk("held accepts", acc, 4);
      chk("held responses", nrsp, 4);
      chk("held last_resp_cycle", last_rsp, 13);
      chk("held ready_cycles", nrdy, 4);
      chk("held rd_cycles", nr, 4);
      chk("held wr_cycles", nw, 2);
      chk("held rdata0", rsp_d[0], 32'h88991234);
      chk("held rdata1", rsp_d[1], 32'h0);
      chk("held rdata2", rsp_d[2], 32'hBEEF3377);
      chk("held rdata3", rsp_d[3], 32'h0);
      chk("held mem3", mem[3], 32'h00000011);
      $display("txn held-valid accepts=%0d responses=%0d last=%0d", acc, nrsp, last_rsp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
